// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
// Holds the default register-file geometry, the register index and
// writeback request types, and the requester identifiers used by the
// writeback arbiter. Port summary: none (package only).
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t            rd;
    logic [XLEN-1:0]     data;
  } wb_req_t;

  // Requester identity doubles as the bit position in the grant vector.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_sel_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// A lone requester is always granted; when both request, the pointer picks
// the winner. The pointer moves to the other requester after every grant,
// and a grant always implies an accepted request because it is only ever
// given to a requester that is asserting req.
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset (pointer -> ALU)
//   req[1:0]   - request vector, bit REQ_ALU / REQ_LSU
//   gnt[1:0]   - one-hot (or zero) grant, combinational from req and pointer
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_sel_e ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == REQ_ALU) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= REQ_ALU;
    end else if (gnt[REQ_ALU]) begin
      ptr <= REQ_LSU;
    end else if (gnt[REQ_LSU]) begin
      ptr <= REQ_ALU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with scoreboard.
// Merges the ALU and load-return writeback channels onto the single
// register-file write port (one write per cycle, one cycle of latency),
// tracks which registers have a write outstanding, and flags protocol
// errors (double issue to a busy register, writeback to an idle one).
// Register 0 is hardwired: writebacks to it are accepted and dropped.
// Ports:
//   clk, rstn                      - clock, asynchronous active-low reset
//   iss_valid, iss_rd              - issued instruction that will write iss_rd
//   alu_valid/ready/rd/data        - ALU writeback request channel
//   lsu_valid/ready/rd/data        - load-return writeback request channel
//   rf_w_en, rf_addr_w, rf_w_data  - register-file write port (registered)
//   busy_mask                      - one bit per register with write pending
//   err                            - sticky protocol-error flag
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter  int XLEN   = rf_pkg::XLEN,
  parameter  int NREG   = rf_pkg::NREG,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_w_en,
  output logic [REG_AW-1:0] rf_addr_w,
  output logic [XLEN-1:0]   rf_w_data,
  output logic [NREG-1:0]   busy_mask,
  output logic              err
);

  logic [1:0]        gnt;
  logic              alu_hs_p0;
  logic              lsu_hs_p0;
  logic [REG_AW-1:0] sel_rd_p0;
  logic [XLEN-1:0]   sel_data_p0;
  logic              vld_p0;
  logic [NREG-1:0]   clr_vec_p0;
  logic [NREG-1:0]   set_vec_p0;
  logic              err_hit_p0;

  logic              vld_p1;
  logic [REG_AW-1:0] addr_p1;
  logic [XLEN-1:0]   data_p1;
  logic [NREG-1:0]   busy_p1;
  logic              err_p1;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  ({lsu_valid, alu_valid}),
    .gnt  (gnt)
  );

  // ---- p0: handshake, source select, scoreboard update terms ----
  // Readies are gated by reset so nothing can handshake while held in reset.
  assign alu_ready = rstn & gnt[REQ_ALU];
  assign lsu_ready = rstn & gnt[REQ_LSU];
  assign alu_hs_p0 = alu_valid & alu_ready;
  assign lsu_hs_p0 = lsu_valid & lsu_ready;

  assign sel_rd_p0   = lsu_hs_p0 ? lsu_rd   : alu_rd;
  assign sel_data_p0 = lsu_hs_p0 ? lsu_data : alu_data;
  // A write to register 0 completes the handshake but never reaches the file.
  assign vld_p0 = (alu_hs_p0 | lsu_hs_p0) && (sel_rd_p0 != '0);

  // Decoding from index 1 keeps bit 0 permanently clear and ignores any
  // index at or above NREG when NREG is not a power of two.
  always_comb begin
    clr_vec_p0 = '0;
    set_vec_p0 = '0;
    for (int i = 1; i < NREG; i++) begin
      clr_vec_p0[i] = vld_p0 && (sel_rd_p0 == REG_AW'(i));
      set_vec_p0[i] = iss_valid && (iss_rd == REG_AW'(i));
    end
  end

  // Issue to a busy register is legal only if that same register is
  // being released on this edge; writeback must find its bit set.
  assign err_hit_p0 = (|(set_vec_p0 & busy_p1 & ~clr_vec_p0)) |
                      (|(clr_vec_p0 & ~busy_p1));

  // ---- p1: registered write port and scoreboard state ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      busy_p1 <= '0;
      err_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= sel_rd_p0;
        data_p1 <= sel_data_p0;
      end
      // Set after clear so a same-edge issue wins.
      busy_p1 <= (busy_p1 & ~clr_vec_p0) | set_vec_p0;
      err_p1  <= err_p1 | err_hit_p0;
    end
  end

  assign rf_w_en   = vld_p1;
  assign rf_addr_w = addr_p1;
  assign rf_w_data = data_p1;
  assign busy_mask = busy_p1;
  assign err       = err_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_rd = '0;
  logic            alu_valid = 1'b0;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            lsu_valid = 1'b0;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd = '0;
  logic [XLEN-1:0] lsu_data = '0;
  logic            rf_w_en;
  logic [AW-1:0]   rf_addr_w;
  logic [XLEN-1:0] rf_w_data;
  logic [NREG-1:0] busy_mask;
  logic            err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit [NREG-1:0]   m_busy;
  bit              m_err;
  int              m_next;   // 0: ALU wins a tie, 1: LSU wins a tie
  bit              m_wen;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  string           grants;

  rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_w_en   (rf_w_en),
    .rf_addr_w (rf_addr_w),
    .rf_w_data (rf_w_data),
    .busy_mask (busy_mask),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_err  = 1'b0;
    m_next = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Holds reset across one rising edge with both requesters asserting,
  // checks the reset values, and releases just after the edge.
  task automatic do_reset();
    rstn = 1'b0;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    iss_valid = 1'b0;
    #1;
    chk("rst_alu_ready", alu_ready, 1'b0);
    chk("rst_lsu_ready", lsu_ready, 1'b0);
    chk("rst_wen", rf_w_en, 1'b0);
    chk("rst_addr", rf_addr_w, '0);
    chk("rst_data", rf_w_data, '0);
    chk("rst_busy", busy_mask, '0);
    chk("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock cycle: check readies against the model, advance the model
  // by the rules of the handshake/scoreboard, then check registered outputs.
  task automatic step(output bit alu_acc, output bit lsu_acc);
    bit ea, el, clr, set;
    int crd, ird;
    logic [XLEN-1:0] cdata;
    #1;
    if (alu_valid && lsu_valid) begin
      ea = (m_next == 0);
      el = !ea;
    end else begin
      ea = alu_valid;
      el = lsu_valid;
    end
    chk("alu_ready", alu_ready, ea);
    chk("lsu_ready", lsu_ready, el);
    alu_acc = ea && alu_valid;
    lsu_acc = el && lsu_valid;
    if (alu_acc) grants = {grants, "A"};
    if (lsu_acc) grants = {grants, "L"};

    clr = 1'b0;
    crd = 0;
    m_wen = 1'b0;
    if (alu_acc || lsu_acc) begin
      crd   = alu_acc ? int'(alu_rd) : int'(lsu_rd);
      cdata = alu_acc ? alu_data : lsu_data;
      m_next = alu_acc ? 1 : 0;
      if (crd != 0) begin
        clr = 1'b1;
        m_wen = 1'b1;
        m_addr = AW'(crd);
        m_data = cdata;
        if (!m_busy[crd]) m_err = 1'b1;
      end
    end
    ird = int'(iss_rd);
    set = iss_valid && (ird != 0);
    if (set && m_busy[ird] && !(clr && crd == ird)) m_err = 1'b1;
    if (clr) m_busy[crd] = 1'b0;
    if (set) m_busy[ird] = 1'b1;

    @(posedge clk);
    #1;
    chk("rf_w_en", rf_w_en, m_wen);
    chk("rf_addr_w", rf_addr_w, m_addr);
    chk("rf_w_data", rf_w_data, m_data);
    chk("busy_mask", busy_mask, m_busy);
    chk("err", err, m_err);
  endtask

  initial begin
    bit aa, la;
    model_reset();
    do_reset();

    // Single ALU writeback, LSU idle
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step(aa, la);
    alu_valid = 1'b0;
    chk("s1_accept", aa, 1'b1);
    chk("s1_wen", rf_w_en, 1'b1);
    chk("s1_addr", rf_addr_w, 5'd5);
    chk("s1_data", rf_w_data, 32'hDEADBEEF);
    step(aa, la);
    chk("s1_wen_drop", rf_w_en, 1'b0);
    chk("s1_data_hold", rf_w_data, 32'hDEADBEEF);

    // Both valid for four cycles from reset: strict alternation
    do_reset();
    grants = "";
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0000;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_0000;
    for (int c = 0; c < 4; c++) begin
      step(aa, la);
      chk("s2_one_write", rf_w_en, 1'b1);
      if (aa) alu_data = alu_data + 1;
      if (la) lsu_data = lsu_data + 1;
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("s2_order", (grants == "ALAL"), 1'b1);

    // Issue rd=7 then LSU writeback rd=7
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step(aa, la);
    iss_valid = 1'b0;
    chk("s3_busy_set", busy_mask[7], 1'b1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
    step(aa, la);
    lsu_valid = 1'b0;
    chk("s3_busy_clr", busy_mask[7], 1'b0);
    chk("s3_err", err, 1'b0);

    // Same-edge issue and writeback to busy rd=3
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd3;
    step(aa, la);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
    step(aa, la);
    iss_valid = 1'b0; alu_valid = 1'b0;
    chk("s4_busy_keep", busy_mask[3], 1'b1);
    chk("s4_err", err, 1'b0);

    // Writeback to rd=0, then writeback to idle rd=9
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hCAFE_0000;
    step(aa, la);
    chk("s5_r0_accept", aa, 1'b1);
    chk("s5_r0_nowrite", rf_w_en, 1'b0);
    chk("s5_r0_busy", busy_mask, '0);
    alu_rd = 5'd9; alu_data = 32'h0000_0009;
    step(aa, la);
    alu_valid = 1'b0;
    chk("s5_r9_write", rf_w_en, 1'b1);
    chk("s5_err_set", err, 1'b1);
    step(aa, la);
    step(aa, la);
    chk("s5_err_sticky", err, 1'b1);

    // Reset pulse in the cycle after a handshake
    do_reset();
    iss_valid = 1'b1; iss_rd = 5'd4;
    step(aa, la);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hBAD0_0012;
    step(aa, la);
    alu_valid = 1'b0;
    chk("s6_pre_wen", rf_w_en, 1'b1);
    chk("s6_pre_err", err, 1'b1);
    rstn = 1'b0;
    #1;
    chk("s6_async_wen", rf_w_en, 1'b0);
    chk("s6_async_busy", busy_mask, '0);
    chk("s6_async_err", err, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    step(aa, la);
    chk("s6_no_write", rf_w_en, 1'b0);
    step(aa, la);

    // Randomized traffic in several reset-separated bursts
    for (int b = 0; b < 4; b++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        if (!alu_valid && $urandom_range(0, 2) != 0) begin
          alu_valid = 1'b1;
          alu_rd = AW'($urandom_range(0, 7));
          alu_data = $urandom;
        end
        if (!lsu_valid && $urandom_range(0, 2) != 0) begin
          lsu_valid = 1'b1;
          lsu_rd = AW'($urandom_range(0, 7));
          lsu_data = $urandom;
        end
        iss_valid = ($urandom_range(0, 3) == 0);
        iss_rd = AW'($urandom_range(0, 7));
        step(aa, la);
        if (aa) alu_valid = 1'b0;
        if (la) lsu_valid = 1'b0;
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      iss_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
